// File: rtl/des_uart_host.sv
// Host-side initiator for the DES UART command protocol.
// Sends a command byte and 8 payload bytes, then checks the echo and collects any text result.
module des_uart_host #(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int TO_W        = 21
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_fStart,
  input  logic [1:0]  i_Op,
  input  logic [63:0] i_Data,
  output logic        o_fBusy,
  output logic        o_fDone,
  output logic        o_fErr,
  output logic [1:0]  o_ErrCode,
  output logic [63:0] o_Text,
  output logic        o_fTx,
  output logic [7:0]  o_TxData,
  input  logic        i_TxReady,
  input  logic        i_TxDone,
  input  logic        i_RxDone,
  input  logic [7:0]  i_RxData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_CMD,
    S_TX_DATA,
    S_RX_RES,
    S_RX_TEXT,
    S_FIN
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [63:0]     payload_q, payload_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            inflight_q, inflight_d;
  logic            tx_q, tx_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [63:0]     text_q, text_d;
  logic [7:0]      cmd;

  assign cmd = {6'b0, op_q};

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      payload_q  <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      inflight_q <= 1'b0;
      tx_q       <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      text_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      payload_q  <= payload_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      inflight_q <= inflight_d;
      tx_q       <= tx_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      text_q     <= text_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    payload_d  = payload_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    inflight_d = inflight_q;
    tx_d       = 1'b0;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    text_d     = text_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_fStart) begin
          op_d       = i_Op;
          payload_d  = i_Data;
          err_d      = 1'b0;
          err_code_d = 2'b00;
          byte_cnt_d = '0;
          state_d    = S_TX_CMD;
        end
      end
      S_TX_CMD: begin
        if (!inflight_q && i_TxReady) begin
          tx_d       = 1'b1;
          inflight_d = 1'b1;
          tx_data_d  = cmd;
        end else if (inflight_q && i_TxDone) begin
          inflight_d = 1'b0;
          state_d    = S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        if (!inflight_q && i_TxReady) begin
          tx_d       = 1'b1;
          inflight_d = 1'b1;
          tx_data_d  = payload_q[63:56];
        end else if (inflight_q && i_TxDone) begin
          inflight_d = 1'b0;
          payload_d  = {payload_q[55:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) begin
            byte_cnt_d = '0;
            to_cnt_d   = '0;
            state_d    = S_RX_RES;
          end
        end
      end
      S_RX_RES: begin
        if (i_RxDone) begin
          if (i_RxData != cmd) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
            state_d    = S_FIN;
          end else if (op_q[1]) begin
            to_cnt_d = '0;
            state_d  = S_RX_TEXT;
          end else begin
            state_d = S_FIN;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d      = 1'b1;
          err_code_d = 2'b01;
          state_d    = S_FIN;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_RX_TEXT: begin
        if (i_RxDone) begin
          text_d     = {text_q[55:0], i_RxData};
          byte_cnt_d = byte_cnt_q + 3'd1;
          to_cnt_d   = '0;
          if (byte_cnt_q == 3'd7) begin
            byte_cnt_d = '0;
            state_d    = S_FIN;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d      = 1'b1;
          err_code_d = 2'b01;
          state_d    = S_FIN;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_fBusy   = (state_q != S_IDLE);
  assign o_fDone   = (state_q == S_FIN);
  assign o_fErr    = err_q;
  assign o_ErrCode = err_code_q;
  assign o_Text    = text_q;
  assign o_fTx     = tx_q;
  assign o_TxData  = tx_data_q;

endmodule

// File: tb/tb_des_uart_host.sv
// Directed bench for des_uart_host with a simple UART_TX model
// and RX bytes injected from the main sequence.
module tb_des_uart_host;

  logic        clk = 1'b0;
  logic        i_Rst;
  logic        i_fStart;
  logic [1:0]  i_Op;
  logic [63:0] i_Data;
  logic        o_fBusy, o_fDone, o_fErr;
  logic [1:0]  o_ErrCode;
  logic [63:0] o_Text;
  logic        o_fTx;
  logic [7:0]  o_TxData;
  logic        i_TxReady;
  logic        i_TxDone = 1'b0;
  logic        i_RxDone;
  logic [7:0]  i_RxData;

  int checks = 0;
  int fails  = 0;

  logic [7:0] txlog [0:255];
  int txn = 0;
  int tx_wait = 0;

  always #5 clk = ~clk;

  des_uart_host #(.TIMEOUT_CYC(50), .TO_W(8)) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_fStart(i_fStart), .i_Op(i_Op),
    .i_Data(i_Data), .o_fBusy(o_fBusy), .o_fDone(o_fDone),
    .o_fErr(o_fErr), .o_ErrCode(o_ErrCode), .o_Text(o_Text),
    .o_fTx(o_fTx), .o_TxData(o_TxData), .i_TxReady(i_TxReady),
    .i_TxDone(i_TxDone), .i_RxDone(i_RxDone), .i_RxData(i_RxData)
  );

  // UART_TX model: logs each strobed byte, reports done 3 cycles later
  always @(posedge clk) begin
    i_TxDone <= 1'b0;
    if (o_fTx) begin
      txlog[txn[7:0]] <= o_TxData;
      txn <= txn + 1;
      tx_wait <= 3;
    end else if (tx_wait == 1) begin
      i_TxDone <= 1'b1;
      tx_wait <= 0;
    end else if (tx_wait > 1) begin
      tx_wait <= tx_wait - 1;
    end
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(logic [1:0] op, logic [63:0] d);
    @(negedge clk);
    i_Op = op;
    i_Data = d;
    i_fStart = 1'b1;
    @(negedge clk);
    i_fStart = 1'b0;
  endtask

  task automatic wait_tx(int base, int n);
    int k = 0;
    while ((txn - base) < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("tx_count", 64'(txn - base), 64'(n));
    repeat (8) @(negedge clk);
  endtask

  task automatic rx(logic [7:0] b);
    @(negedge clk);
    i_RxDone = 1'b1;
    i_RxData = b;
    @(negedge clk);
    i_RxDone = 1'b0;
  endtask

  task automatic rx8(logic [63:0] t);
    for (int i = 7; i >= 0; i--) rx(t[i*8 +: 8]);
  endtask

  task automatic wait_done(int lim, output int cyc);
    cyc = 0;
    while (!o_fDone && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 64'(o_fDone), 64'd1);
  endtask

  task automatic check_tx(string tag, int base, logic [63:0] cmd_data, logic [7:0] cmd);
    check({tag, "_cmd"}, 64'(txlog[base[7:0]]), 64'(cmd));
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = base + 1 + i;
      check({tag, "_byte"}, 64'(txlog[idx[7:0]]), 64'(cmd_data[(7-i)*8 +: 8]));
    end
  endtask

  initial begin
    int base;
    int cyc;
    int dcount;
    i_Rst = 1'b0;
    i_fStart = 1'b0;
    i_Op = 2'b00;
    i_Data = '0;
    i_TxReady = 1'b1;
    i_RxDone = 1'b0;
    i_RxData = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(o_fBusy), 64'd0);
    check("rst_done", 64'(o_fDone), 64'd0);
    check("rst_err", 64'(o_fErr), 64'd0);
    check("rst_code", 64'(o_ErrCode), 64'd0);
    check("rst_text", o_Text, 64'd0);
    check("rst_ftx", 64'(o_fTx), 64'd0);
    check("rst_txdata", 64'(o_TxData), 64'd0);
    i_Rst = 1'b1;
    repeat (2) @(negedge clk);

    // key load
    base = txn;
    start(2'b00, 64'h133457799BBCDFF1);
    check("key_busy", 64'(o_fBusy), 64'd1);
    wait_tx(base, 9);
    check_tx("key_tx", base, 64'h133457799BBCDFF1, 8'h00);
    rx(8'h00);
    wait_done(100, cyc);
    check("key_err", 64'(o_fErr), 64'd0);
    check("key_code", 64'(o_ErrCode), 64'd0);
    check("key_text", o_Text, 64'd0);
    @(negedge clk);
    check("key_done_pulse", 64'(o_fDone), 64'd0);
    check("key_idle", 64'(o_fBusy), 64'd0);

    // encrypt
    base = txn;
    start(2'b10, 64'h0123456789ABCDEF);
    wait_tx(base, 9);
    check_tx("enc_tx", base, 64'h0123456789ABCDEF, 8'h02);
    rx(8'h02);
    rx8(64'h85E813540F0AB405);
    wait_done(100, cyc);
    check("enc_code", 64'(o_ErrCode), 64'd0);
    check("enc_err", 64'(o_fErr), 64'd0);
    check("enc_text", o_Text, 64'h85E813540F0AB405);

    // decrypt
    base = txn;
    start(2'b11, 64'h85E813540F0AB405);
    wait_tx(base, 9);
    check("dec_cmd", 64'(txlog[base[7:0]]), 64'h03);
    rx(8'h03);
    rx8(64'h1122334455667788);
    wait_done(100, cyc);
    check("dec_code", 64'(o_ErrCode), 64'd0);
    check("dec_text", o_Text, 64'h1122334455667788);

    // response mismatch
    base = txn;
    start(2'b10, 64'hFEDCBA9876543210);
    wait_tx(base, 9);
    rx(8'h00);
    wait_done(100, cyc);
    check("mis_code", 64'(o_ErrCode), 64'd2);
    check("mis_err", 64'(o_fErr), 64'd1);
    rx(8'h5A);
    repeat (5) @(negedge clk);
    check("mis_text", o_Text, 64'h1122334455667788);
    check("mis_err_held", 64'(o_fErr), 64'd1);
    check("mis_code_held", 64'(o_ErrCode), 64'd2);

    // start strobe during TX_DATA is ignored
    base = txn;
    start(2'b10, 64'h0123456789ABCDEF);
    check("ign_err_clr", 64'(o_fErr), 64'd0);
    check("ign_code_clr", 64'(o_ErrCode), 64'd0);
    repeat (15) @(negedge clk);
    i_Op = 2'b01;
    i_Data = 64'hFFFF_FFFF_FFFF_FFFF;
    i_fStart = 1'b1;
    @(negedge clk);
    i_fStart = 1'b0;
    wait_tx(base, 9);
    repeat (10) @(negedge clk);
    check("ign_tx_total", 64'(txn - base), 64'd9);
    check_tx("ign_tx", base, 64'h0123456789ABCDEF, 8'h02);
    rx(8'h02);
    rx8(64'hA0A1A2A3A4A5A6A7);
    wait_done(100, cyc);
    check("ign_code", 64'(o_ErrCode), 64'd0);
    check("ign_text", o_Text, 64'hA0A1A2A3A4A5A6A7);

    // timeout after 3 text bytes
    base = txn;
    start(2'b10, 64'h0);
    wait_tx(base, 9);
    rx(8'h02);
    rx(8'hC1);
    rx(8'hC2);
    rx(8'hC3);
    wait_done(200, cyc);
    check("to_cycles", 64'(cyc), 64'd50);
    check("to_code", 64'(o_ErrCode), 64'd1);
    check("to_err", 64'(o_fErr), 64'd1);
    check("to_text", o_Text, 64'hA3A4A5A6A7C1C2C3);

    // reset during RX_TEXT
    base = txn;
    start(2'b10, 64'h0);
    wait_tx(base, 9);
    rx(8'h02);
    rx(8'hD1);
    rx(8'hD2);
    i_Rst = 1'b0;
    #1;
    check("mrst_busy", 64'(o_fBusy), 64'd0);
    check("mrst_done", 64'(o_fDone), 64'd0);
    check("mrst_err", 64'(o_fErr), 64'd0);
    check("mrst_code", 64'(o_ErrCode), 64'd0);
    check("mrst_text", o_Text, 64'd0);
    check("mrst_ftx", 64'(o_fTx), 64'd0);
    check("mrst_txdata", 64'(o_TxData), 64'd0);
    repeat (2) @(negedge clk);
    i_Rst = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_fDone) dcount++;
    end
    check("mrst_no_done", 64'(dcount), 64'd0);
    check("mrst_idle", 64'(o_fBusy), 64'd0);

    // normal transaction after reset
    base = txn;
    start(2'b10, 64'h0011223344556677);
    wait_tx(base, 9);
    check_tx("post_tx", base, 64'h0011223344556677, 8'h02);
    rx(8'h02);
    rx8(64'hCAFEF00DDEADBEEF);
    wait_done(100, cyc);
    check("post_code", 64'(o_ErrCode), 64'd0);
    check("post_err", 64'(o_fErr), 64'd0);
    check("post_text", o_Text, 64'hCAFEF00DDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
